coord_cmd_packetizer: RTL and testbench

Converts one binary (x, y) target command from the vision pipeline into a fixed-length ASCII frame, `X<dddd>Y<dddd>\n`, and streams it one byte at a time into the command translator's UART transmitter. The block sits directly upstream of the UART TX. Its byte-side valid/ready handshake connects straight to the TX's `valid`/`data_tx`/`tx_ready`. Binary-to-decimal conversion is iterative double-dabble, so no dividers are used.

---
 rtl/coord_cmd_packetizer.sv | 147 ++++++++++++++
 tb/tb_coord_cmd_packetizer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coord_cmd_packetizer.sv
// coord_cmd_packetizer: turns one binary (x,y) command into the ASCII
// frame "X<dddd>Y<dddd>\n" and streams it out one byte at a time.
// Ports: clk, reset (sync, active-high);
//        cmd_x/cmd_y/cmd_valid/cmd_ready : command input handshake;
//        byte_data/byte_valid/byte_ready : byte stream to the UART TX;
//        frame_done : one-cycle pulse when the final '\n' is accepted.
module coord_cmd_packetizer #(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               frame_done
);

  localparam int CW = $clog2(COORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [15:0]        bx_q, bx_d;
  logic [15:0]        by_q, by_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  function automatic logic [15:0] dabble(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] n);
    return {4'h3, n};
  endfunction

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    bx_d       = bx_q;
    by_d       = by_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cmd_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          bx_d    = '0;
          by_d    = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bx_d  = (dabble(bx_q) << 1) | 16'(x_q[COORD_W-1]);
        by_d  = (dabble(by_q) << 1) | 16'(y_q[COORD_W-1]);
        x_d   = x_q << 1;
        y_d   = y_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(COORD_W - 1)) begin
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        byte_valid = 1'b1;
        case (idx_q)
          4'd0:    byte_data = 8'h58;
          4'd1:    byte_data = dig(bx_q[15:12]);
          4'd2:    byte_data = dig(bx_q[11:8]);
          4'd3:    byte_data = dig(bx_q[7:4]);
          4'd4:    byte_data = dig(bx_q[3:0]);
          4'd5:    byte_data = 8'h59;
          4'd6:    byte_data = dig(by_q[15:12]);
          4'd7:    byte_data = dig(by_q[11:8]);
          4'd8:    byte_data = dig(by_q[7:4]);
          4'd9:    byte_data = dig(by_q[3:0]);
          4'd10:   byte_data = 8'h0A;
          default: byte_data = 8'h00;
        endcase
        if (byte_ready) begin
          if (idx_q == 4'd10) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // No handshake of either side may complete while reset is held.
    if (reset) begin
      cmd_ready  = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_coord_cmd_packetizer.sv
// Bench for coord_cmd_packetizer: a COORD_W=11 and a COORD_W=13 instance,
// each with its own command queue, byte-ready driver and reference model.
module tb_coord_cmd_packetizer;

  localparam int W0 = 11;
  localparam int W1 = 13;
  localparam int UART_PER = 4340;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic [12:0] cx  [2];
  logic [12:0] cy  [2];
  logic        cv  [2];
  logic        cr  [2];
  logic [7:0]  bd  [2];
  logic        bv  [2];
  logic        br  [2];
  logic        fd  [2];

  coord_cmd_packetizer #(.COORD_W(W0)) u11 (
    .clk(clk), .reset(rst[0]),
    .cmd_x(cx[0][10:0]), .cmd_y(cy[0][10:0]),
    .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .byte_data(bd[0]), .byte_valid(bv[0]),
    .byte_ready(br[0]), .frame_done(fd[0])
  );

  coord_cmd_packetizer #(.COORD_W(W1)) u13 (
    .clk(clk), .reset(rst[1]),
    .cmd_x(cx[1]), .cmd_y(cy[1]),
    .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .byte_data(bd[1]), .byte_valid(bv[1]),
    .byte_ready(br[1]), .frame_done(fd[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;
  int rmode = 0;
  bit gap = 0;

  logic [25:0] cq   [2][$];
  logic [87:0] flog [2][$];
  int          glog [2][$];

  bit          act [2];
  int          age [2];
  int          nb  [2];
  logic [87:0] efr [2];
  int acc_cyc [2];
  int fv_cyc  [2];
  int fd_cyc  [2];
  int bsa     [2];
  int tbytes  [2];
  bit acc_now [2];
  logic [87:0] got [2];
  logic bvp [2];
  logic brp [2];
  logic rstp [2];
  logic [7:0] bdp [2];
  int ucnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dg(input int n);
    return 8'(48 + n);
  endfunction

  function automatic logic [87:0] mkframe(input int x, input int y);
    return {8'h58, dg(x / 1000 % 10), dg(x / 100 % 10),
            dg(x / 10 % 10), dg(x % 10),
            8'h59, dg(y / 1000 % 10), dg(y / 100 % 10),
            dg(y / 10 % 10), dg(y % 10), 8'h0A};
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; age[d] = 0; nb[d] = 0;
      bsa[d] = 0; tbytes[d] = 0; acc_now[d] = 0;
      got[d] = '0; efr[d] = '0;
      acc_cyc[d] = 0; fv_cyc[d] = 0; fd_cyc[d] = 0;
    end
  end

  // Compare process: every cycle, DUT outputs against the frame model.
  always @(negedge clk) begin : cmp
    int w;
    logic er, ev, edn;
    logic [7:0] ed;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        w = (d == 0) ? W0 : W1;
        if (rst[d]) begin
          er = 0; ev = 0; ed = 8'h00; edn = 0;
        end else begin
          er  = !act[d];
          ev  = act[d] && (age[d] > w);
          ed  = ev ? efr[d][8*(10-nb[d]) +: 8] : 8'h00;
          edn = ev && br[d] && (nb[d] == 10);
        end
        checks++;
        if ({cr[d], bv[d], bd[d], fd[d]} !== {er, ev, ed, edn}) begin
          failures++;
          $display("FAIL model dut%0d cyc=%0d rdy/val/data/done got %b %b %h %b want %b %b %h %b",
                   d, cyc, cr[d], bv[d], bd[d], fd[d], er, ev, ed, edn);
        end
        if (!rst[d] && !rstp[d] && bvp[d] && !brp[d]) begin
          checks++;
          if (!bv[d] || bd[d] !== bdp[d]) begin
            failures++;
            $display("FAIL hold dut%0d cyc=%0d got val=%b data=%h want val=1 data=%h",
                     d, cyc, bv[d], bd[d], bdp[d]);
          end
        end
        acc_now[d] = bv[d] && br[d];
        if (bv[d] && !bvp[d]) fv_cyc[d] = cyc;
        if (cv[d] && cr[d]) begin
          acc_cyc[d] = cyc;
          bsa[d] = 0;
          glog[d].push_back(cyc - fd_cyc[d]);
          if (cq[d].size() != 0) void'(cq[d].pop_front());
        end
        if (bv[d] && br[d]) begin
          got[d] = {got[d][79:0], bd[d]};
          bsa[d]++;
          tbytes[d]++;
        end
        if (fd[d]) begin
          fd_cyc[d] = cyc;
          flog[d].push_back(got[d]);
        end
        // Advance the model to the next cycle.
        if (rst[d]) begin
          act[d] = 0;
        end else if (act[d]) begin
          if (ev && br[d]) begin
            if (nb[d] == 10) act[d] = 0;
            else nb[d]++;
          end
          age[d]++;
        end else if (cv[d]) begin
          act[d] = 1;
          age[d] = 1;
          nb[d]  = 0;
          efr[d] = mkframe(int'(cx[d]) % (1 << w),
                           int'(cy[d]) % (1 << w));
        end
        bvp[d]  = bv[d];
        brp[d]  = br[d];
        bdp[d]  = bd[d];
        rstp[d] = rst[d];
      end
    end
  end

  // Input driver: command queues and byte_ready patterns.
  initial begin
    for (int d = 0; d < 2; d++) begin
      cv[d] = 0; cx[d] = '0; cy[d] = '0; br[d] = 0; ucnt[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (acc_now[d]) ucnt[d] = UART_PER - 1;
        acc_now[d] = 0;
        if (cq[d].size() != 0) begin
          cv[d] = gap ? ($urandom_range(3) != 0) : 1'b1;
          cx[d] = cq[d][0][25:13];
          cy[d] = cq[d][0][12:0];
        end else begin
          cv[d] = 1'b0;
        end
        case (rmode)
          0: br[d] = 1'b1;
          1: br[d] = ($urandom_range(9) < 6);
          default: begin
            if (ucnt[d] > 0) begin
              ucnt[d]--;
              br[d] = 1'b0;
            end else begin
              br[d] = ($urandom_range(7) != 0);
            end
          end
        endcase
      end
    end
  end

  task automatic push(input int d, input int x, input int y);
    cq[d].push_back({13'(x), 13'(y)});
  endtask

  task automatic push2(input int x, input int y);
    push(0, x, y);
    push(1, x, y);
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      flog[d].delete();
      glog[d].delete();
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, g, e);
    end
  endtask

  task automatic chk_frame(input int d, input int k,
                           input logic [87:0] e, input string nm);
    checks++;
    if (flog[d].size() <= k) begin
      failures++;
      $display("FAIL %s dut%0d frame %0d missing, got %0d frames",
               nm, d, k, flog[d].size());
    end else if (flog[d][k] !== e) begin
      failures++;
      $display("FAIL %s dut%0d got %h want %h", nm, d, flog[d][k], e);
    end
  endtask

  function automatic int gl(input int d, input int k);
    if (glog[d].size() <= k) return -1;
    return glog[d][k];
  endfunction

  task automatic wait_idle(input int budget, input string nm);
    int t;
    t = 0;
    while ((act[0] || act[1] || cq[0].size() != 0 ||
            cq[1].size() != 0) && t < budget) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= budget) begin
      failures++;
      $display("FAIL %s timeout got %0d cycles want <%0d", nm, t, budget);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_act(input int d, input string nm);
    int t;
    t = 0;
    while (!act[d] && t < 100) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL %s accept timeout got %0d want <100", nm, t);
    end
  endtask

  initial begin : main
    int t;
    int snap [2];
    rst[0] = 1; rst[1] = 1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk);
    #1 rst[0] = 0; rst[1] = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_int("rst_ready", int'(cr[d]), 1);
      chk_int("rst_valid", int'(bv[d]), 0);
      chk_int("rst_data", int'(bd[d]), 0);
    end

    // Basic frame.
    clr();
    push2(123, 45);
    wait_idle(200, "basic");
    for (int d = 0; d < 2; d++) begin
      chk_frame(d, 0, {"X0123Y0045", 8'h0A}, "basic");
      chk_int("basic_frames", flog[d].size(), 1);
    end
    chk_int("lat_w11", fv_cyc[0] - acc_cyc[0], 12);
    chk_int("lat_w13", fv_cyc[1] - acc_cyc[1], 14);

    // Extreme values.
    clr();
    push2(2047, 1023);
    push2(0, 0);
    wait_idle(200, "extreme");
    for (int d = 0; d < 2; d++) begin
      chk_frame(d, 0, {"X2047Y1023", 8'h0A}, "ext_max");
      chk_frame(d, 1, {"X0000Y0000", 8'h0A}, "ext_zero");
      chk_int("ext_gap", gl(d, 1), 1);
    end

    // Back-to-back with held cmd_valid.
    clr();
    push2(1, 2);
    push2(999, 8191);
    wait_idle(200, "b2b");
    chk_frame(1, 0, {"X0001Y0002", 8'h0A}, "b2b_a");
    chk_frame(1, 1, {"X0999Y8191", 8'h0A}, "b2b_b");
    chk_frame(0, 1, {"X0999Y2047", 8'h0A}, "b2b_w11");
    chk_int("b2b_gap", gl(1, 1), 1);

    // Backpressure from a UART-rate ready, second command held off.
    clr();
    rmode = 2;
    push2(321, 654);
    push2(5, 6);
    t = 0;
    while ((flog[0].size() < 1 || flog[1].size() < 1) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk_int("bp_timeout", int'(t < 60000), 1);
    rmode = 0;
    wait_idle(400, "bp");
    for (int d = 0; d < 2; d++) begin
      chk_frame(d, 0, {"X0321Y0654", 8'h0A}, "bp_a");
      chk_frame(d, 1, {"X0005Y0006", 8'h0A}, "bp_b");
      chk_int("bp_gap", gl(d, 1), 1);
    end

    // Random commands, random ready, random cmd_valid gaps.
    clr();
    rmode = 1;
    gap = 1;
    for (int i = 0; i < 24; i++) begin
      for (int d = 0; d < 2; d++) begin
        push(d, $urandom_range(8191), $urandom_range(8191));
      end
    end
    wait_idle(8000, "random");
    gap = 0;
    rmode = 0;
    for (int d = 0; d < 2; d++) chk_int("rand_frames", flog[d].size(), 24);

    // Reset after the 5th byte.
    for (int d = 0; d < 2; d++) begin
      clr();
      push(d, 4321, 8765);
      wait_act(d, "rmid");
      t = 0;
      while (bsa[d] < 5 && t < 100) begin
        @(posedge clk);
        t++;
      end
      chk_int("rmid_bytes", bsa[d], 5);
      #1 rst[d] = 1;
      @(negedge clk);
      chk_int("rmid_valid", int'(bv[d]), 0);
      chk_int("rmid_done", int'(fd[d]), 0);
      @(posedge clk);
      #1 rst[d] = 0;
      @(negedge clk);
      chk_int("rmid_ready", int'(cr[d]), 1);
      push(d, 7, 7);
      wait_idle(200, "rmid");
      chk_frame(d, 0, {"X0007Y0007", 8'h0A}, "rmid_new");
      chk_int("rmid_frames", flog[d].size(), 1);
    end

    // Reset in the middle of conversion.
    clr();
    push2(100, 200);
    wait_act(0, "rconv");
    repeat (3) @(posedge clk);
    #1 rst[0] = 1; rst[1] = 1;
    snap[0] = tbytes[0];
    snap[1] = tbytes[1];
    @(posedge clk);
    #1 rst[0] = 0; rst[1] = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_int("rconv_ready", int'(cr[d]), 1);
    repeat (40) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_int("rconv_bytes", tbytes[d] - snap[d], 0);
      chk_int("rconv_frames", flog[d].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
